// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the I/D memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MARB_IDLE   = 2'd0,
    MARB_ACCESS = 2'd1,
    MARB_DONE   = 2'd2
  } marb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } marb_owner_e;

  // Access-cycle counter width; a TIMEOUT of 0 still gets a 1-bit counter.
  function automatic int tcnt_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: clear/enable up-counter flagging the last allowed cycle.
module mem_arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = tcnt_width(TIMEOUT);
  localparam logic [CW-1:0] TC_VAL = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear takes priority; otherwise count once per enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero TIMEOUT never fires, so a stalled memory simply waits forever.
  assign tc = (TIMEOUT != 0) && en && (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data-stage requests onto one memory port.
//
// state       | meaning
// ------------+-------------------------------------------------------
// MARB_IDLE   | port free; arbitrate and latch the winner's operands
// MARB_ACCESS | strobes and operands held; wait for m_ready or timeout
// MARB_DONE   | one-cycle ack (and err on abort) to the owner
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_read,
  output logic          m_write,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          err
);

  localparam int RW = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_D_RUN);

  marb_state_e   state_q, state_d;
  marb_owner_e   owner_q, owner_d;
  logic [RW-1:0] d_run_q, d_run_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          m_read_q, m_read_d;
  logic          m_write_q, m_write_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          abort_q, abort_d;

  logic grant_d;
  logic start;
  logic done_ok;
  logic abort;
  logic tmo_tc;

  // D wins a tie unless it has already used its run while I was waiting.
  assign grant_d = d_req && (!i_req || (d_run_q != RUN_MAX));
  assign start   = (state_q == MARB_IDLE) && (i_req || d_req);
  assign done_ok = (state_q == MARB_ACCESS) && m_ready;
  assign abort   = (state_q == MARB_ACCESS) && !m_ready && tmo_tc;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != MARB_ACCESS),
    .en   (state_q == MARB_ACCESS),
    .tc   (tmo_tc)
  );

  // State and datapath registers; reset also kills any in-flight strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MARB_IDLE;
      owner_q   <= OWN_I;
      d_run_q   <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      d_run_q   <= d_run_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MARB_IDLE:   if (start) state_d = MARB_ACCESS;
      MARB_ACCESS: if (done_ok || abort) state_d = MARB_DONE;
      MARB_DONE:   state_d = MARB_IDLE;
      default:     state_d = MARB_IDLE;
    endcase
  end

  // Operand latch on grant, fairness counter, and result capture on completion.
  always_comb begin
    owner_d   = owner_q;
    d_run_d   = d_run_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    abort_d   = abort_q;

    if (start) begin
      owner_d   = grant_d ? OWN_D : OWN_I;
      m_addr_d  = grant_d ? d_addr : i_addr;
      m_wdata_d = grant_d ? d_wdata : '0;
      m_read_d  = grant_d ? !d_we : 1'b1;
      m_write_d = grant_d && d_we;
      abort_d   = 1'b0;
      if (grant_d && i_req) begin
        if (d_run_q != RUN_MAX) d_run_d = d_run_q + RW'(1);
      end else begin
        d_run_d = '0;
      end
    end

    if (done_ok || abort) begin
      m_read_d  = 1'b0;
      m_write_d = 1'b0;
      abort_d   = abort;
      if (owner_q == OWN_D) begin
        d_rdata_d = done_ok ? m_rdata : '0;
      end else begin
        i_rdata_d = done_ok ? m_rdata : '0;
      end
    end
  end

  // Outputs: acks and err only ever appear in DONE, so they cannot collide.
  always_comb begin
    i_ack   = (state_q == MARB_DONE) && (owner_q == OWN_I);
    d_ack   = (state_q == MARB_DONE) && (owner_q == OWN_D);
    err     = (state_q == MARB_DONE) && abort_q;
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
    m_addr  = m_addr_q;
    m_wdata = m_wdata_q;
    m_read  = m_read_q;
    m_write = m_write_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an ack scoreboard and a latency-programmable memory.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, m_wdata, m_rdata, i_rdata, d_rdata;
  logic          i_ack, d_ack, m_read, m_write, m_ready, err;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_RUN(MAXR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  typedef struct {
    bit            is_d;
    logic [DW-1:0] rdata;
    bit            chk;
    bit            err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_lat = 1;   // ACCESS cycle (1-based) in which m_ready rises; 0 = never
  int   acc_cnt = 0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [DW-1:0] rd, input bit chk, input bit e);
    exp_t x;
    x.is_d = is_d; x.rdata = rd; x.chk = chk; x.err = e;
    sb.push_back(x);
  endtask

  // Wait for n acks within a cycle budget; optionally drop the acked requester's req.
  task automatic wait_acks(input int n, input int budget, input bit drop);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) begin
        got++;
        if (drop && i_ack) i_req = 1'b0;
        if (drop && d_ack) d_req = 1'b0;
      end
    end
    check("ack_count", 32'(got), 32'(n));
  endtask

  // Memory model: answers in the rdy_lat-th cycle that a strobe is up.
  initial begin
    m_ready = 1'b0;
    m_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (m_read || m_write) begin
        acc_cnt++;
        if (rdy_lat != 0 && acc_cnt == rdy_lat) begin
          m_ready = 1'b1;
          m_rdata = mem_fn(m_addr);
        end else begin
          m_ready = 1'b0;
          m_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        acc_cnt = 0;
        m_ready = 1'b0;
        m_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Scoreboard: every ack is matched against the next expected completion.
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      check("ack_collision", 32'(i_ack && d_ack), 32'd0);
      check("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("ack_owner_d", 32'(d_ack), 32'(mon_e.is_d));
        check("ack_err", 32'(err), 32'(mon_e.err));
        if (mon_e.chk) check("ack_rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h200; d_addr = 32'h300; d_wdata = '0;

    // 1. reset with both requests pending
    repeat (3) @(negedge clk);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_acks", 32'({i_ack, d_ack, err}), 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    push(1'b1, mem_fn(32'h300), 1'b1, 1'b0);
    push(1'b0, mem_fn(32'h200), 1'b1, 1'b0);
    rdy_lat = 1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_m_read", 32'(m_read), 32'd1);
    check("t1_m_addr_d", m_addr, 32'h300);
    wait_acks(2, 20, 1'b1);

    // 2. single I read, fastest memory
    @(negedge clk);
    i_addr = 32'h40; i_req = 1'b1;
    push(1'b0, 32'h8C22_0004, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_m_read", 32'(m_read), 32'd1);
    check("t2_m_write", 32'(m_write), 32'd0);
    check("t2_m_addr", m_addr, 32'h40);
    check("t2_early_ack", 32'(i_ack), 32'd0);
    @(negedge clk);
    check("t2_i_ack", 32'(i_ack), 32'd1);
    check("t2_d_ack", 32'(d_ack), 32'd0);
    i_req = 1'b0;

    // 3. D write with memory answering in its third access cycle
    @(negedge clk);
    rdy_lat = 3;
    d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
    push(1'b1, '0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_m_write", 32'(m_write), 32'd1);
      check("t3_m_read", 32'(m_read), 32'd0);
      check("t3_m_addr", m_addr, 32'h100);
      check("t3_m_wdata", m_wdata, 32'hCAFE_F00D);
      check("t3_no_ack", 32'(d_ack), 32'd0);
    end
    @(negedge clk);
    check("t3_d_ack", 32'(d_ack), 32'd1);
    check("t3_strobe_off", 32'(m_write), 32'd0);
    d_req = 1'b0; d_we = 1'b0;

    // 4. both requesters saturating the port: D x4 then I, twice
    @(negedge clk);
    rdy_lat = 1;
    i_addr = 32'h200; d_addr = 32'h300;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < MAXR; k++) push(1'b1, mem_fn(32'h300), 1'b1, 1'b0);
      push(1'b0, mem_fn(32'h200), 1'b1, 1'b0);
    end
    i_req = 1'b1; d_req = 1'b1;
    wait_acks(10, 100, 1'b0);
    i_req = 1'b0; d_req = 1'b0;

    // 5. D read against a memory that never answers, then a normal I read
    @(negedge clk);
    rdy_lat = 0;
    d_addr = 32'h380; d_req = 1'b1;
    push(1'b1, '0, 1'b1, 1'b1);
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      check("t5_m_read", 32'(m_read), 32'd1);
      check("t5_no_ack", 32'(d_ack), 32'd0);
    end
    @(negedge clk);
    check("t5_d_ack", 32'(d_ack), 32'd1);
    check("t5_err", 32'(err), 32'd1);
    check("t5_strobe_off", 32'(m_read), 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    check("t5_err_pulse", 32'(err), 32'd0);
    rdy_lat = 1;
    i_addr = 32'h40; i_req = 1'b1;
    push(1'b0, 32'h8C22_0004, 1'b1, 1'b0);
    wait_acks(1, 10, 1'b1);

    // 6. reset asserted mid-access
    @(negedge clk);
    rdy_lat = 0;
    d_addr = 32'h3C0; d_req = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_m_read_pre", 32'(m_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_m_read_async", 32'(m_read), 32'd0);
    check("t6_m_addr_async", m_addr, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_no_ack", 32'({i_ack, d_ack, err}), 32'd0);
      check("t6_idle_strobe", 32'(m_read | m_write), 32'd0);
    end
    rdy_lat = 1;
    d_addr = 32'h300; d_req = 1'b1;
    push(1'b1, mem_fn(32'h300), 1'b1, 1'b0);
    @(negedge clk);
    check("t6_restart_m_read", 32'(m_read), 32'd1);
    wait_acks(1, 10, 1'b1);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
